// File: rtl/jio_pkg.sv
// Shared constants and strobe decoding for the jcscpu I/O port.
// Status bit positions, device IDs and the strobe classification enum.
package jio_pkg;

   localparam int ST_KBD   = 7;
   localparam int ST_FULL  = 6;
   localparam int ST_EMPTY = 5;
   localparam int ST_OVF   = 4;

   localparam int DEV_TTY = 0;
   localparam int DEV_KBD = 0;

   // NONE is encoded as zero so that a reset register holds "no pending action".
   typedef enum logic [2:0] {
      NONE    = 3'd0,
      WR_ADDR = 3'd1,
      WR_DATA = 3'd2,
      RD_STAT = 3'd3,
      RD_DATA = 3'd4
   } strobe_e;

   function automatic strobe_e decode_strobe(input logic io_io, input logic io_da,
                                             input logic dev0);
      if (io_io) return io_da ? WR_ADDR : WR_DATA;
      if (io_da) return RD_STAT;
      return dev0 ? RD_DATA : NONE;
   endfunction

endpackage

// File: rtl/jio_fifo.sv
// Synchronous FIFO for the TTY output stream (used when JIO_TTY_FIFO_EN is defined).
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module jio_fifo #(
   parameter int DW    = 8,
   parameter int DEPTH = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   input  logic                       push_i,
   input  logic [DW-1:0]              data_i,
   output logic                       full_o,
   input  logic                       pop_i,
   output logic [DW-1:0]              data_o,
   output logic                       valid_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [AW-1:0] PTR_ONE = AW'(1);

   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          pop_ok, push_ok;

   assign valid_o = (count_q != '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign data_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

   assign pop_ok  = pop_i & valid_o;
   assign push_ok = push_i & (~full_o | pop_ok);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_ONE;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
         count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
      end
   end

   // NOTE: storage is not reset; the pointers and count alone define which entries are live.
   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/jio_port.sv
// CPU I/O port: address select, NDEV channel registers, TTY output stream, keyboard input.
// Define JIO_TTY_FIFO_EN for a TTY_DEPTH-entry TTY FIFO; otherwise the TTY is a single register.
module jio_port
   import jio_pkg::*;
#(
   parameter int NDEV      = 4,
   parameter int DW        = 8,
   parameter int TTY_DEPTH = 8
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 io_s,
   input  logic                 io_e,
   input  logic                 io_da,
   input  logic                 io_io,
   input  logic [DW-1:0]        bus_in,
   output logic [DW-1:0]        bus_out,
   output logic [DW-1:0]        sel_dev,
   output logic [NDEV*DW-1:0]   dev_out,
   output logic [DW-1:0]        tty_data,
   output logic                 tty_valid,
   input  logic                 tty_ready,
   input  logic [DW-1:0]        kbd_data,
   input  logic                 kbd_strobe,
   output logic                 kbd_pending
);

   logic          io_s_q, io_s_qq, io_e_q;
   strobe_e       rd_kind_q, rd_kind_d, wr_kind, consume;
   logic [DW-1:0] sel_q, kbd_q;
   logic          pend_q, ovf_q;
   logic [DW-1:0] ch_q [1:NDEV-1];
   logic          dev0, wr_evt;
   logic          tty_push, tty_pop, tty_drop, tty_full;
   logic [DW-1:0] status;

   assign dev0    = (sel_q == DW'(DEV_KBD));
   // The event is taken from the registered copies, so the write lands two edges after io_s rises.
   assign wr_evt  = io_s_q & ~io_s_qq;
   assign wr_kind = wr_evt ? decode_strobe(io_io, io_da, dev0) : NONE;
   assign rd_kind_d = io_e ? decode_strobe(io_io, io_da, dev0) : NONE;
   assign consume = (io_e_q & ~io_e) ? rd_kind_q : NONE;

   assign tty_push = (wr_kind == WR_DATA) && (sel_q == DW'(DEV_TTY));
   assign tty_pop  = tty_valid & tty_ready;

`ifdef JIO_TTY_FIFO_EN
   localparam int CW = $clog2(TTY_DEPTH) + 1;
   logic [CW-1:0] tty_count;

   jio_fifo #(.DW(DW), .DEPTH(TTY_DEPTH)) u_tty_fifo (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .push_i  (tty_push),
      .data_i  (bus_in),
      .full_o  (tty_full),
      .pop_i   (tty_ready),
      .data_o  (tty_data),
      .valid_o (tty_valid),
      .count_o (tty_count)
   );

   assign tty_drop = tty_push & (tty_count == CW'(TTY_DEPTH)) & ~tty_pop;
`else
   logic [DW-1:0] tty_q;
   logic          tty_v_q;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tty_q   <= '0;
         tty_v_q <= 1'b0;
      end else if (tty_push && (!tty_v_q || tty_pop)) begin
         tty_q   <= bus_in;
         tty_v_q <= 1'b1;
      end else if (tty_pop) begin
         tty_v_q <= 1'b0;
      end
   end

   assign tty_data  = tty_q;
   assign tty_valid = tty_v_q;
   assign tty_full  = tty_v_q;
   assign tty_drop  = tty_push & tty_v_q & ~tty_pop;
`endif

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         io_s_q    <= 1'b0;
         io_s_qq   <= 1'b0;
         io_e_q    <= 1'b0;
         rd_kind_q <= NONE;
         sel_q     <= '0;
         kbd_q     <= '0;
         pend_q    <= 1'b0;
         ovf_q     <= 1'b0;
         for (int i = 1; i < NDEV; i++) ch_q[i] <= '0;
      end else begin
         io_s_q    <= io_s;
         io_s_qq   <= io_s_q;
         io_e_q    <= io_e;
         rd_kind_q <= rd_kind_d;

         if (wr_kind == WR_ADDR) sel_q <= bus_in;
         for (int i = 1; i < NDEV; i++) begin
            if (wr_kind == WR_DATA && sel_q == DW'(i)) ch_q[i] <= bus_in;
         end

         // A fresh keyboard byte outranks a consume landing on the same edge.
         if (kbd_strobe) begin
            kbd_q  <= kbd_data;
            pend_q <= 1'b1;
         end else if (consume == RD_DATA) begin
            pend_q <= 1'b0;
         end

         if (tty_drop)                ovf_q <= 1'b1;
         else if (consume == RD_STAT) ovf_q <= 1'b0;
      end
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      status           = '0;
      status[ST_KBD]   = pend_q;
      status[ST_FULL]  = tty_full;
      status[ST_EMPTY] = ~tty_valid;
      status[ST_OVF]   = ovf_q;
   end

   always_comb begin
      bus_out = '0;
      if (io_e && !io_io) begin
         if (io_da)     bus_out = status;
         else if (dev0) bus_out = kbd_q;
      end
   end

   assign sel_dev         = sel_q;
   assign kbd_pending     = pend_q;
   assign dev_out[DW-1:0] = '0;

   for (genvar g = 1; g < NDEV; g++) begin : g_dev
      assign dev_out[g*DW +: DW] = ch_q[g];
   end

endmodule

// File: doc/jio_port.md
# jio_port

Parametrised CPU I/O port for the jcscpu core, replacing the ad-hoc TTY latch in the top level. It decodes the control unit's IO strobes (io_s, io_e, io_da, io_io) into an address-select register, NDEV output channels, a buffered TTY output stream with a ready/valid drain, and a keyboard input holding register with status. It sits between the CPU bus and the board peripherals: seven-segment display, LEDs, and button/switch capture.

## Interface
- NDEV, 4: number of output channels; channel 0 is the TTY, channels 1..NDEV-1 are plain latched registers.
- DW, 8: bus and data width.
- TTY_DEPTH, 8: TTY FIFO depth; must be a power of 2 and at least 2.

Ports:
- CLK  in  1  system clock; the only clock.
- RST_N  in  1  reset, asynchronous and active-low.
- io_s  in  1  CPU IO set strobe, level, may last many CLK cycles.
- io_e  in  1  CPU IO enable strobe, level.
- io_da  in  1  1 = address cycle, 0 = data cycle.
- io_io  in  1  1 = output (CPU to device), 0 = input (device to CPU).
- bus_in  in  DW  CPU bus value.
- bus_out  out  DW  read data for the CPU bus; 0 whenever not driving, so it is wor-safe.
- sel_dev  out  DW  currently selected device address.
- dev_out  out  NDEV*DW  channel registers; the slice for channel 0 is always 0.
- tty_data  out  DW  head of the TTY FIFO.
- tty_valid  out  1  TTY FIFO not empty.
- tty_ready  in  1  consumer accepts the head this cycle.
- kbd_data  in  DW  keyboard byte.
- kbd_strobe  in  1  one-cycle capture pulse.
- kbd_pending  out  1  unread keyboard byte present.

## Operation
- Write event: the first CLK cycle in which io_s is 1 and was 0 in the previous cycle, detected through a registered copy of io_s. Exactly one write happens per strobe.
- Write decode, with io_io=1:
  - io_da=1: sel_dev <= bus_in.
  - io_da=0, sel_dev==0: push bus_in to the TTY FIFO. If the FIFO is full, drop the byte and set the sticky overflow flag.
  - io_da=0, 1<=sel_dev<NDEV: channel register[sel_dev] <= bus_in.
  - io_da=0, any other sel_dev: ignored.
- Write strobes with io_io=0 are ignored.
- Read, with io_e=1 and io_io=0 (combinational):
  - io_da=1: bus_out = status = {kbd_pending, tty_full, ~tty_valid, overflow, 0...}, MSB first.
  - io_da=0, sel_dev==0: bus_out = keyboard holding register.
  - io_da=0, other sel_dev: bus_out = 0.
- Read consume: on the falling edge of io_e, the registered effect depends on the cycle type.
  - Data read of device 0 clears kbd_pending.
  - Status read clears overflow.
- Keyboard: kbd_strobe loads the holding register and sets kbd_pending. A new byte overwrites an unread byte.
- Keyboard simultaneous strobe and consume: the strobe wins. kbd_pending stays 1 and the register holds the new byte.
- TTY pop: occurs when tty_valid && tty_ready.
  - Push and pop in the same cycle on a full FIFO: both are accepted, no overflow.
  - Push on an empty FIFO: tty_valid rises the next cycle. There is no bypass.
  - Pointers wrap modulo TTY_DEPTH.
  - Occupancy counter is clog2(TTY_DEPTH)+1 bits wide.

## Timing
- Reset values (asynchronous on RST_N=0): all registers, pointers and flags are 0. Consequences:
  - sel_dev=0, dev_out=0, tty_valid=0, kbd_pending=0, overflow=0.
  - bus_out=0 unless io_e is asserted.
- Write latency: the target register or FIFO updates on the clock edge after the io_s rising edge is detected. That is 2 edges after io_s first goes high at the input.
- Read data: combinational from io_e, io_da, io_io and state, with no latency.
- Read clear: takes effect one edge after io_e falls.
- Reset mid-strobe: the edge detector resets to 0. A strobe still high after RST_N deasserts counts as a new write event.

## Configuration
- JIO_TTY_FIFO_EN
  - Defined: TTY path is a TTY_DEPTH-entry FIFO as above.
  - Undefined: TTY path is a single register. tty_full = tty_valid, TTY_DEPTH is ignored, and push-while-full follows the same drop and overflow rule.

## Structure
- Package jio_pkg holds:
  - Status bit index constants: ST_KBD=7, ST_FULL=6, ST_EMPTY=5, ST_OVF=4.
  - Device IDs: DEV_TTY=0, DEV_KBD=0.
  - The strobe-decode enum: WR_ADDR, WR_DATA, RD_STAT, RD_DATA, NONE.
- Sub-module jio_fifo (parameters DW and DEPTH) provides push/full, pop/valid, a count output and the simultaneous-operation rule. It is used only under JIO_TTY_FIFO_EN.

## Test plan
- Address write 0x02, then data write 0xA5 -> dev_out channel 2 = 0xA5, other channels 0; a strobe held 10 cycles writes once.
- Address 0, data writes 0x11..0x18 with tty_ready=0 -> 8 entries, status bit 6 set; a 9th write (0x19) is dropped and overflow=1; a status read returns 0x50 and overflow clears after io_e falls.
- tty_ready=1 drain -> tty_data sequence 0x11..0x18 in order, then tty_valid=0; push and pop on the same edge when full keeps the count at 8.
- kbd_strobe with 0x41, then data read of device 0 -> bus_out=0x41 and kbd_pending clears after io_e falls; a strobe in the same cycle as the consume edge leaves pending=1.
- RST_N low mid-stream -> all outputs 0 asynchronously, FIFO empty, sel_dev=0.
- With the macro undefined, two TTY writes without a drain -> only the first is kept and overflow=1.
